// File: rtl/keypad_scanner.sv
// Matrix keypad scanner: one-hot column drive, synchronised row sampling,
// press/release debounce with 2-key lockout, optional typematic repeat, valid/ready key output.
module keypad_scanner #(
  parameter int ROWS            = 4,
  parameter int COLS            = 4,
  parameter int SETTLE_CYCLES   = 4,
  parameter int DEBOUNCE_CYCLES = 8,
  parameter int REPEAT_CYCLES   = 0,
  localparam int CW             = $clog2(ROWS*COLS)
) (
  input  logic            clk,
  input  logic            nrst,
  input  logic [ROWS-1:0] row_d,
  output logic [COLS-1:0] col_q,
  output logic [CW-1:0]   key_code,
  output logic            key_valid,
  input  logic            key_ready,
  output logic            key_held,
  output logic            multi_key_err,
  output logic            overrun
);
  localparam int CLW = $clog2(COLS);
  localparam int RW  = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int SW  = $clog2(SETTLE_CYCLES);
  localparam int DW  = $clog2(DEBOUNCE_CYCLES+1);
  localparam int PW  = $clog2(REPEAT_CYCLES+2);

  typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD, RELEASE} state_e;

  state_e            state_q, state_d;
  logic [ROWS-1:0]   row_m_q, row_s_q;
  logic [CLW-1:0]    col_idx_q, col_idx_d, col_next;
  logic [SW-1:0]     settle_q, settle_d;
  logic [DW-1:0]     deb_q, deb_d;
  logic [PW-1:0]     rep_q, rep_d;
  logic [ROWS-1:0]   cand_oh_q, cand_oh_d;
  logic [CLW-1:0]    cand_col_q, cand_col_d;
  logic              extra_q, extra_d;
  logic              emit, err_d;
  logic [RW-1:0]     cand_row;
  logic [CW-1:0]     code;
  logic              valid_q, err_q, ovr_q;
  logic [CW-1:0]     code_q;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) state_q <= SCAN;
    else       state_q <= state_d;
  end

  assign col_next = (col_idx_q == CLW'(COLS-1)) ? '0 : col_idx_q + 1'b1;

  always_comb begin
    cand_row = '0;
    for (int r = 0; r < ROWS; r++)
      if (cand_oh_q[r]) cand_row = RW'(r);
  end
  assign code = CW'(cand_row) * CW'(COLS) + CW'(cand_col_q);

  always_comb begin
    state_d    = state_q;
    col_idx_d  = col_idx_q;
    settle_d   = settle_q;
    deb_d      = deb_q;
    rep_d      = rep_q;
    cand_oh_d  = cand_oh_q;
    cand_col_d = cand_col_q;
    extra_d    = 1'b0;
    emit       = 1'b0;
    err_d      = 1'b0;
    case (state_q)
      SCAN: begin
        settle_d = settle_q + 1'b1;
        if (settle_q == SW'(SETTLE_CYCLES-1)) begin
          settle_d = '0;
          if ($countones(row_s_q) == 1) begin
            state_d    = DEBOUNCE;
            cand_oh_d  = row_s_q;
            cand_col_d = col_idx_q;
            deb_d      = '0;
          end else begin
            col_idx_d = col_next;
            err_d     = (row_s_q != '0);
          end
        end
      end
      DEBOUNCE: begin
        if (row_s_q == cand_oh_q) begin
          deb_d = deb_q + 1'b1;
          if (deb_q == DW'(DEBOUNCE_CYCLES-1)) begin
            state_d = HELD;
            emit    = 1'b1;
            deb_d   = '0;
            rep_d   = '0;
          end
        end else begin
          state_d   = SCAN;
          col_idx_d = col_next;
          settle_d  = '0;
          deb_d     = '0;
        end
      end
      HELD: begin
        // Extra rows only flag an error on their rising edge; the held key keeps ownership.
        extra_d = |(row_s_q & ~cand_oh_q);
        err_d   = extra_d & ~extra_q;
        if (REPEAT_CYCLES > 0) begin
          rep_d = rep_q + 1'b1;
          if (rep_q == PW'((REPEAT_CYCLES > 0) ? REPEAT_CYCLES-1 : 0)) begin
            rep_d = '0;
            emit  = 1'b1;
          end
        end
        // The first zero cycle already counts toward release debounce.
        if (row_s_q == '0) begin
          if (DEBOUNCE_CYCLES == 1) begin
            state_d   = SCAN;
            col_idx_d = col_next;
            settle_d  = '0;
          end else begin
            state_d = RELEASE;
            deb_d   = DW'(1);
          end
        end
      end
      RELEASE: begin
        if (row_s_q == '0) begin
          deb_d = deb_q + 1'b1;
          if (deb_q == DW'(DEBOUNCE_CYCLES-1)) begin
            state_d   = SCAN;
            col_idx_d = col_next;
            settle_d  = '0;
            deb_d     = '0;
          end
        end else begin
          state_d = HELD;
          deb_d   = '0;
        end
      end
      default: state_d = SCAN;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      row_m_q    <= '0;
      row_s_q    <= '0;
      col_idx_q  <= '0;
      settle_q   <= '0;
      deb_q      <= '0;
      rep_q      <= '0;
      cand_oh_q  <= '0;
      cand_col_q <= '0;
      extra_q    <= 1'b0;
      valid_q    <= 1'b0;
      code_q     <= '0;
      err_q      <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      row_m_q    <= row_d;
      row_s_q    <= row_m_q;
      col_idx_q  <= col_idx_d;
      settle_q   <= settle_d;
      deb_q      <= deb_d;
      rep_q      <= rep_d;
      cand_oh_q  <= cand_oh_d;
      cand_col_q <= cand_col_d;
      extra_q    <= extra_d;
      err_q      <= err_d;
      ovr_q      <= emit && valid_q && !key_ready;
      // A slot freed by acceptance this cycle can take the new emission directly.
      if (emit && (!valid_q || key_ready)) begin
        valid_q <= 1'b1;
        code_q  <= code;
      end else if (valid_q && key_ready) begin
        valid_q <= 1'b0;
      end
    end
  end

  always_comb begin
    col_q         = COLS'(1) << col_idx_q;
    key_held      = (state_q == HELD) || (state_q == RELEASE);
    key_valid     = valid_q;
    key_code      = code_q;
    multi_key_err = err_q;
    overrun       = ovr_q;
  end
endmodule
